// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin two-master Wishbone arbiter (SERV ibus/dbus) with idle gap and watchdog
module wb_arbiter #(
    parameter int          TIMEOUT   = 255,
    parameter int          TIMEOUT_W = 8,
    parameter logic [31:0] ERR_RDT   = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_wb_ibus_adr,
    input  logic        i_wb_ibus_cyc,
    output logic [31:0] o_wb_ibus_rdt,
    output logic        o_wb_ibus_ack,
    input  logic [31:0] i_wb_dbus_adr,
    input  logic [31:0] i_wb_dbus_dat,
    input  logic [3:0]  i_wb_dbus_sel,
    input  logic        i_wb_dbus_we,
    input  logic        i_wb_dbus_cyc,
    output logic [31:0] o_wb_dbus_rdt,
    output logic        o_wb_dbus_ack,
    output logic [31:0] o_wb_cpu_adr,
    output logic [31:0] o_wb_cpu_dat,
    output logic [3:0]  o_wb_cpu_sel,
    output logic        o_wb_cpu_we,
    output logic        o_wb_cpu_cyc,
    input  logic [31:0] i_wb_cpu_rdt,
    input  logic        i_wb_cpu_ack,
    output logic        o_timeout
);
    localparam logic [TIMEOUT_W-1:0] WD_MAX = TIMEOUT[TIMEOUT_W-1:0];

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

    state_t               state;
    logic                 prefer_d;
    logic [TIMEOUT_W-1:0] wd;
    logic                 gnt_i;
    logic                 gnt_d;
    logic                 m_cyc;
    logic                 timeout_hit;
    logic                 m_ack;

    // Shared-port mux and ack/rdt steering; a real ack always beats the watchdog
    always_comb begin
        gnt_i         = state == GNT_I;
        gnt_d         = state == GNT_D;
        m_cyc         = (gnt_i && i_wb_ibus_cyc) || (gnt_d && i_wb_dbus_cyc);
        timeout_hit   = m_cyc && wd == WD_MAX;
        m_ack         = m_cyc && (i_wb_cpu_ack || timeout_hit);
        o_wb_cpu_cyc  = m_cyc;
        o_wb_cpu_adr  = gnt_i ? i_wb_ibus_adr : i_wb_dbus_adr;
        o_wb_cpu_dat  = i_wb_dbus_dat;
        o_wb_cpu_sel  = gnt_i ? 4'hF : i_wb_dbus_sel;
        o_wb_cpu_we   = !gnt_i && i_wb_dbus_we;
        o_wb_ibus_ack = gnt_i && m_ack;
        o_wb_dbus_ack = gnt_d && m_ack;
        o_wb_ibus_rdt = (timeout_hit && !i_wb_cpu_ack) ? ERR_RDT : i_wb_cpu_rdt;
        o_wb_dbus_rdt = o_wb_ibus_rdt;
    end

    // Grant FSM: one transaction per grant, always returning through IDLE so cyc drops between grants
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            prefer_d  <= 1'b1;
            wd        <= '0;
            o_timeout <= 1'b0;
        end else begin
            o_timeout <= timeout_hit && !i_wb_cpu_ack;
            case (state)
                IDLE: begin
                    if (i_wb_dbus_cyc && (!i_wb_ibus_cyc || prefer_d)) begin
                        state    <= GNT_D;
                        prefer_d <= 1'b0;
                        wd       <= '0;
                    end else if (i_wb_ibus_cyc) begin
                        state    <= GNT_I;
                        prefer_d <= 1'b1;
                        wd       <= '0;
                    end
                end
                default: begin
                    if (!m_cyc || m_ack)
                        state <= IDLE;
                    else
                        wd <= wd + 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed and random checks of wb_arbiter against a transaction-level model
module tb_wb_arbiter;
    localparam int          TO  = 4;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ibus_adr, dbus_adr, dbus_dat, cpu_rdt;
    logic        ibus_cyc, dbus_cyc, dbus_we, cpu_ack;
    logic [3:0]  dbus_sel;
    logic [31:0] ibus_rdt, dbus_rdt, cpu_adr, cpu_dat;
    logic        ibus_ack, dbus_ack, cpu_we, cpu_cyc, tmo;
    logic [3:0]  cpu_sel;

    int    n_chk = 0, n_fail = 0;
    int    owner, age;
    bit    tie_d, exp_to, auto_ack, keep;
    int    ack_i, ack_d, n_to;
    string order;
    logic [31:0] last_irdt, last_drdt;

    always #5 clk = ~clk;

    wb_arbiter #(.TIMEOUT(TO), .TIMEOUT_W(8), .ERR_RDT(ERR)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_wb_ibus_adr(ibus_adr), .i_wb_ibus_cyc(ibus_cyc),
        .o_wb_ibus_rdt(ibus_rdt), .o_wb_ibus_ack(ibus_ack),
        .i_wb_dbus_adr(dbus_adr), .i_wb_dbus_dat(dbus_dat), .i_wb_dbus_sel(dbus_sel),
        .i_wb_dbus_we(dbus_we), .i_wb_dbus_cyc(dbus_cyc),
        .o_wb_dbus_rdt(dbus_rdt), .o_wb_dbus_ack(dbus_ack),
        .o_wb_cpu_adr(cpu_adr), .o_wb_cpu_dat(cpu_dat), .o_wb_cpu_sel(cpu_sel),
        .o_wb_cpu_we(cpu_we), .o_wb_cpu_cyc(cpu_cyc),
        .i_wb_cpu_rdt(cpu_rdt), .i_wb_cpu_ack(cpu_ack),
        .o_timeout(tmo)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chks(input string tag, input string got, input string exp);
        n_chk++;
        assert (got == exp) else begin
            n_fail++;
            $error("FAIL %s: got '%s' expected '%s'", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        ack_i = 0; ack_d = 0; n_to = 0; order = "";
    endtask

    // One clock: check outputs at the falling edge, advance the model at the rising edge
    task automatic step();
        bit c, hit, ack;
        int prev;
        logic [31:0] rdt;
        #4;
        c   = (owner == 1 && ibus_cyc) || (owner == 2 && dbus_cyc);
        hit = c && age == TO;
        ack = c && (cpu_ack || hit);
        rdt = (hit && !cpu_ack) ? ERR : cpu_rdt;
        chk("cpu_cyc",  32'(cpu_cyc), 32'(c));
        chk("cpu_adr",  cpu_adr, owner == 1 ? ibus_adr : dbus_adr);
        chk("cpu_dat",  cpu_dat, dbus_dat);
        chk("cpu_sel",  32'(cpu_sel), 32'(owner == 1 ? 4'hF : dbus_sel));
        chk("cpu_we",   32'(cpu_we), 32'(owner != 1 && dbus_we));
        chk("ibus_ack", 32'(ibus_ack), 32'(owner == 1 && ack));
        chk("dbus_ack", 32'(dbus_ack), 32'(owner == 2 && ack));
        chk("ibus_rdt", ibus_rdt, rdt);
        chk("dbus_rdt", dbus_rdt, rdt);
        chk("timeout",  32'(tmo), 32'(exp_to));
        if (ibus_ack === 1'b1) begin ack_i++; order = {order, "I"}; last_irdt = ibus_rdt; end
        if (dbus_ack === 1'b1) begin ack_d++; order = {order, "D"}; last_drdt = dbus_rdt; end
        if (tmo === 1'b1) n_to++;
        prev = owner;
        @(posedge clk);
        if (rst) begin
            owner = 0; age = 0; tie_d = 1; exp_to = 0;
        end else begin
            exp_to = hit && !cpu_ack;
            if (owner == 0) begin
                if (ibus_cyc || dbus_cyc) begin
                    owner = (dbus_cyc && (!ibus_cyc || tie_d)) ? 2 : 1;
                    tie_d = owner == 1;
                    age   = 0;
                end
            end else if (!c || ack) owner = 0;
            else age++;
        end
        #1;
        if (!keep && ack && !rst) begin
            if (prev == 1) ibus_cyc = 0; else dbus_cyc = 0;
        end
        if (auto_ack) cpu_ack = c && !cpu_ack && !rst;
    endtask

    initial begin
        rst = 1; ibus_adr = 0; ibus_cyc = 0; dbus_adr = 0; dbus_dat = 0; dbus_sel = 0;
        dbus_we = 0; dbus_cyc = 0; cpu_rdt = 0; cpu_ack = 0;
        auto_ack = 0; keep = 0; last_irdt = 0; last_drdt = 0;
        clear_counts();
        @(posedge clk); #1;
        owner = 0; age = 0; tie_d = 1; exp_to = 0;
        step();
        rst = 0;

        // single ibus read
        clear_counts();
        auto_ack = 1; ibus_adr = 32'h100; ibus_cyc = 1; cpu_rdt = 32'hCAFE0001;
        dbus_adr = 32'h2000; dbus_sel = 4'h3; dbus_we = 1;
        repeat (4) step();
        chk("single_iacks", 32'(ack_i), 32'd1);
        chk("single_dacks", 32'(ack_d), 32'd0);
        chk("single_irdt", last_irdt, 32'hCAFE0001);

        // tie from reset: dbus first
        rst = 1; step(); rst = 0;
        clear_counts();
        ibus_cyc = 1; dbus_cyc = 1; ibus_adr = 32'h40; dbus_adr = 32'h80; dbus_we = 0; dbus_sel = 4'hF;
        repeat (8) step();
        chks("tie_order", order, "DI");

        // continuous requests alternate
        clear_counts();
        keep = 1; ibus_cyc = 1; dbus_cyc = 1;
        repeat (18) step();
        chks("rr_order", order, "DIDIDI");
        keep = 0; ibus_cyc = 0; dbus_cyc = 0;
        repeat (2) step();

        // watchdog on a dbus write
        clear_counts();
        auto_ack = 0; cpu_ack = 0; dbus_cyc = 1; dbus_we = 1; dbus_sel = 4'h5;
        dbus_dat = 32'h1234_5678; dbus_adr = 32'h3000; cpu_rdt = 32'h5555_AAAA;
        repeat (6) step();
        cpu_ack = 1;
        step();
        cpu_ack = 0;
        step();
        chk("to_dacks", 32'(ack_d), 32'd1);
        chk("to_drdt", last_drdt, ERR);
        chk("to_pulses", 32'(n_to), 32'd1);

        // dbus abort with ibus pending
        clear_counts();
        dbus_cyc = 1; dbus_we = 0;
        step(); step();
        ibus_cyc = 1; ibus_adr = 32'h500;
        step();
        dbus_cyc = 0;
        step(); step();
        auto_ack = 1;
        repeat (3) step();
        chk("abort_dacks", 32'(ack_d), 32'd0);
        chk("abort_iacks", 32'(ack_i), 32'd1);
        chk("abort_to", 32'(n_to), 32'd0);

        // reset during ibus grant, then a tie
        clear_counts();
        ibus_cyc = 1;
        step();
        rst = 1; step(); rst = 0;
        dbus_cyc = 1;
        repeat (6) step();
        chks("rst_tie_order", order, "DI");
        ibus_cyc = 0; dbus_cyc = 0; auto_ack = 0; cpu_ack = 0;
        step();

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            rst = $urandom_range(99) == 0;
            if (!ibus_cyc) begin
                ibus_cyc = $urandom_range(2) == 0; ibus_adr = $urandom;
            end else if ($urandom_range(39) == 0) ibus_cyc = 0;
            if (!dbus_cyc) begin
                dbus_cyc = $urandom_range(2) == 0; dbus_adr = $urandom; dbus_dat = $urandom;
                dbus_sel = 4'($urandom); dbus_we = 1'($urandom);
            end else if ($urandom_range(39) == 0) dbus_cyc = 0;
            cpu_ack = $urandom_range(2) == 0;
            cpu_rdt = $urandom;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Two-master Wishbone arbiter that shares the single CPU-side slave port (the `wb_mux` input, which fans out to memory and GPIO) between the SERV instruction bus (ibus, read-only) and data bus (dbus). The arbiter:
- grants one master at a time, round-robin on ties;
- holds the grant for one complete transaction;
- inserts the idle cycle the downstream single-cycle ack generator needs between transactions;
- runs a watchdog that terminates hung transactions with an error ack.

## Interface

Parameters:
- `TIMEOUT`, default 255: grant cycles without a downstream ack before the arbiter self-acks. Legal range 1 .. 2^TIMEOUT_W-1.
- `TIMEOUT_W`, default 8: watchdog counter width.
- `ERR_RDT`, default 32'h0000_0000: read data returned on a timeout ack.

Ports:
- `i_clk` in 1: clock.
- `i_rst` in 1: reset. Synchronous, active-high; clock is i_clk.
- `i_wb_ibus_adr` in 32: ibus address.
- `i_wb_ibus_cyc` in 1: ibus request.
- `o_wb_ibus_rdt` out 32: ibus read data.
- `o_wb_ibus_ack` out 1: ibus ack.
- `i_wb_dbus_adr` in 32: dbus address.
- `i_wb_dbus_dat` in 32: dbus write data.
- `i_wb_dbus_sel` in 4: dbus byte select.
- `i_wb_dbus_we` in 1: dbus write enable.
- `i_wb_dbus_cyc` in 1: dbus request.
- `o_wb_dbus_rdt` out 32: dbus read data.
- `o_wb_dbus_ack` out 1: dbus ack.
- `o_wb_cpu_adr` out 32: shared-port address.
- `o_wb_cpu_dat` out 32: shared-port write data.
- `o_wb_cpu_sel` out 4: shared-port byte select.
- `o_wb_cpu_we` out 1: shared-port write enable.
- `o_wb_cpu_cyc` out 1: shared-port request.
- `i_wb_cpu_rdt` in 32: shared-port read data.
- `i_wb_cpu_ack` in 1: shared-port ack.
- `o_timeout` out 1: one-cycle pulse when a transaction is terminated by the watchdog.

## Operation

State machine: IDLE, GNT_I, GNT_D.

Registered state:
- 1-bit pointer `prefer_d`; reset value 1 (dbus wins the first tie).
- Watchdog counter `wd`, TIMEOUT_W bits.

Transitions:
- IDLE, only one cyc high: go to that master's grant state.
- IDLE, both cyc high: go to GNT_D if `prefer_d`, else GNT_I.
- Entering any grant state: `wd` <= 0, and `prefer_d` <= (granted master is ibus). The non-granted master is preferred next.
- Grant state, granted master's cyc low (abort): return to IDLE. No ack is issued and `o_timeout` stays 0.
- Grant state, `i_wb_cpu_ack`=1: forward the ack, then go to IDLE.
- Grant state, no ack and `wd`==TIMEOUT: self-ack the granted master with rdt=ERR_RDT, assert `o_timeout`, then go to IDLE.
- Grant state, no ack and `wd`<TIMEOUT: increment `wd`.
- If the real ack and the timeout occur in the same cycle, the real ack wins: rdt comes from downstream and `o_timeout`=0.

Outputs:
- `o_wb_cpu_cyc` = (GNT_I & i_wb_ibus_cyc) | (GNT_D & i_wb_dbus_cyc). It is 0 in IDLE.
- In GNT_I: adr=ibus adr, we=0, sel=4'hF, dat=dbus dat (don't care).
- Otherwise (GNT_D or IDLE): all fields come from dbus.
- `o_wb_x_ack` = granted(x) & master cyc & (i_wb_cpu_ack | timeout_hit). Combinational; the non-granted master's ack is always 0.
- `o_wb_x_rdt` = timeout_hit & !i_wb_cpu_ack ? ERR_RDT : i_wb_cpu_rdt.
- A downstream ack arriving in IDLE (late or stray) is ignored.

Reset: state IDLE, `prefer_d`=1, `wd`=0, `o_timeout`=0. This gives `o_wb_cpu_cyc`=0 and both acks 0 in the cycle after the reset edge. Reset asserted mid-transaction abandons the transaction: no ack is forwarded.

## Timing

- Request cyc high in IDLE cycle k: grant state and `o_wb_cpu_cyc`=1 from cycle k+1.
- With the registered single-cycle downstream ack: downstream ack in k+2, master ack in k+2 (same cycle, combinational).
- After an ack, the arbiter is in IDLE at k+3 and `o_wb_cpu_cyc`=0 for at least that one cycle. This guarantees the downstream ack generator never issues a second ack.
- A request pending at k+3 is granted at k+4. Back-to-back transactions use 3 cycles each.
- Timeout: self-ack in the (TIMEOUT+1)-th grant cycle. `o_timeout` is a registered pulse in the following cycle.

## Test plan

- Single ibus read, adr=0x100, downstream acks one cycle after cyc with rdt=0xCAFE0001: `o_wb_cpu_cyc` rises 1 cycle after the request; `o_wb_ibus_ack`=1 with rdt 0xCAFE0001; we=0 and sel=F during the grant; `o_wb_dbus_ack` stays 0.
- ibus and dbus cyc both high from reset: dbus granted first, then ibus. Exactly one idle cycle between grants; each master receives exactly one ack.
- Both masters hold cyc continuously for 6 transactions: grants alternate D, I, D, I, D, I. `o_wb_cpu_cyc` drops for one cycle after every ack.
- TIMEOUT=4, downstream never acks a dbus write: dbus ack in the 5th grant cycle with rdt=ERR_RDT; `o_timeout` pulses once; a late downstream ack in the next cycle is not forwarded.
- dbus drops cyc after 2 grant cycles with ibus pending: no dbus ack, no timeout; ibus granted 2 cycles later.
- `i_rst` asserted during GNT_I: in the next cycle `o_wb_cpu_cyc`=0, acks are 0, and a subsequent tie goes to dbus.
